tdc_sum_sched: RTL and testbench
================================

# tdc_sum_sched

Frame scheduler for the 16-channel TDC summing datapath (x50 multiply, fraction add, 5-stage adder tree, 6-cycle latency). It collects one coarse/fine hit per enabled channel, closes the frame on completion or timeout, and issues a single start to the datapath. It then checks that the datapath's data-valid returns in time and averages 2^navg frame sums before presenting a result. It sits between the per-channel TDC front ends and the readout logic.

## Interface
Parameters:
- NCH, 16, channel count (the datapath is fixed at 16).
- LAT, 6, datapath start-to-dval latency in cycles.
- TMO_W, 12, timeout counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- ch_vld  in  NCH  per-channel hit strobe, 1-cycle.
- ch_int  in  10 x NCH  coarse count; valid with ch_vld.
- ch_frac  in  7 x NCH  fine count; valid with ch_vld.
- cfg_mask  in  NCH  channel enable.
- cfg_timeout  in  TMO_W  frame timeout in cycles; 0 = no timeout.
- cfg_navg  in  4  log2 of frames to average; values >8 are treated as 8.
- dp_start  out  1  datapath start pulse.
- dp_int  out  10 x NCH  to datapath.
- dp_frac  out  7 x NCH  to datapath.
- dp_sum  in  37  datapath sum.
- dp_dval  in  1  datapath valid.
- res_data  out  37  averaged sum.
- res_vld  out  1  result strobe, 1-cycle.
- res_partial  out  1  at least one frame in the batch timed out; valid with res_vld.
- busy  out  1  state != IDLE.
- err_lost  out  1  1-cycle pulse: a hit was dropped.
- err_dval  out  1  1-cycle pulse: the datapath did not respond.

Reset values: all outputs 0, all capture registers 0, accumulator 0, frame count 0, FSM IDLE.

## Operation
FSM states are IDLE, COLLECT, ISSUE, WAIT, ACC.
- **IDLE:** on any ch_vld & cfg_mask != 0:
  - latch cfg_mask and cfg_timeout into frame shadows;
  - capture those channels and set their got bits;
  - go to COLLECT, or to ISSUE if got == mask.
- **IDLE, cfg_mask == 0:** all hits are ignored; no error is flagged.
- **COLLECT, capture:** each channel captures only its first hit. A hit on a channel whose got bit is set is discarded and pulses err_lost. Hits on masked-off channels are ignored silently.
- **COLLECT, exit:** go to ISSUE when got == mask, including a completing hit in the current cycle. Also go to ISSUE when the timer reaches the shadow timeout; that frame is flagged partial.
- **COLLECT, timer:** the timer counts from 0, starting in the first COLLECT cycle.
- **ISSUE:** dp_start = 1 for exactly one cycle, then go to WAIT.
  - dp_int/dp_frac present the capture registers, with missing or masked channels forced to 0.
  - They are held stable from ISSUE until leaving WAIT.
- **WAIT:** count cycles.
  - On dp_dval, go to ACC.
  - If LAT+2 cycles elapse without dp_dval, pulse err_dval, discard the frame (accumulator and frame count unchanged) and return to IDLE.
- **ACC:**
  - acc += dp_sum (45-bit accumulator, no overflow possible for navg ≤ 8); frame_cnt++; partial_acc |= frame partial.
  - If frame_cnt == 2^navg_shadow: res_data = acc[navg+36:navg] (truncating shift), res_vld = 1, res_partial = partial_acc; then clear acc, frame_cnt and partial_acc.
  - Always return to IDLE and clear the got bits.
- **navg_shadow:** latched from cfg_navg when frame_cnt == 0 at IDLE→COLLECT/ISSUE. A change mid-batch takes effect at the next batch.
- **Hits outside IDLE/COLLECT:** any ch_vld & mask during ISSUE/WAIT/ACC is dropped and pulses err_lost.
- **Reset mid-operation:** asynchronously returns to IDLE with all state cleared. A dp_dval arriving after reset in IDLE is ignored.

## Timing
- Hits sampled at edge t completing the frame → dp_start high during cycle t+1.
- dp_dval is expected at cycle t+1+LAT.
- ACC occupies the cycle after dp_dval; res_vld is registered and asserts one cycle after ACC.
- Minimum frame period is 1 (capture) + 1 (ISSUE) + LAT (WAIT) + 1 (ACC) = LAT+3 cycles. A new frame can begin capturing on the cycle after ACC.
- err_lost and err_dval are registered and assert one cycle after the triggering condition.

## Test plan
- mask=0x0001, navg=0, ch0 hit int=10 frac=3, model datapath (LAT=6, Σint·50+frac) → dp_start 1 cycle after hit; res_data=503, res_partial=0 at start+8.
- mask=0xFFFF, all 16 hits int=1 frac=1 spread over 20 cycles, navg=0 → one dp_start after the last hit; res_data=816.
- mask=0x0003, timeout=50, only ch0 hit int=2 frac=0 → dp_start at timeout; dp_int[1]=0; res_data=100, res_partial=1.
- navg=2, four frames with ch0 sums 100, 101, 102, 103 → one res_vld only after the 4th frame; res_data=101.
- ch0 hits twice in COLLECT, plus a hit during WAIT → err_lost pulses twice; the first capture is used.
- Datapath model withholds dval → err_dval pulse at start+LAT+2, no res_vld, FSM back in IDLE. Assert rst mid-WAIT → all outputs 0, busy=0.

Source files
------------

// File: rtl/tdc_sum_sched.sv
// Frame scheduler for the 16-channel TDC summing datapath: gathers one hit per enabled
// channel, issues a datapath start, supervises the returning dval and averages 2^navg sums.
module tdc_sum_sched #(
  parameter int NCH   = 16,
  parameter int LAT   = 6,
  parameter int TMO_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       ch_vld,
  input  logic [10*NCH-1:0]    ch_int,
  input  logic [7*NCH-1:0]     ch_frac,
  input  logic [NCH-1:0]       cfg_mask,
  input  logic [TMO_W-1:0]     cfg_timeout,
  input  logic [3:0]           cfg_navg,
  output logic                 dp_start,
  output logic [10*NCH-1:0]    dp_int,
  output logic [7*NCH-1:0]     dp_frac,
  input  logic [36:0]          dp_sum,
  input  logic                 dp_dval,
  output logic [36:0]          res_data,
  output logic                 res_vld,
  output logic                 res_partial,
  output logic                 busy,
  output logic                 err_lost,
  output logic                 err_dval
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    ACC     = 3'd4
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(LAT);

  state_t             state;
  state_t             state_nxt;
  logic [NCH-1:0]     got;
  logic [NCH-1:0]     got_nxt;
  logic [NCH-1:0]     take;
  logic [NCH-1:0]     mask_sh;
  logic [TMO_W-1:0]   tmo_sh;
  logic [TMO_W-1:0]   timer;
  logic               partial;
  logic [7:0]         wait_cnt;
  logic [3:0]         navg_sh;
  logic [8:0]         frame_cnt;
  logic [44:0]        acc;
  logic               partial_acc;
  logic [36:0]        sum_q;
  logic [9:0]         cap_int  [NCH];
  logic [6:0]         cap_frac [NCH];

  logic               lost;
  logic               start_frame;
  logic               tmo_hit;
  logic               dval_miss;
  logic               load_dp;
  logic [3:0]         navg_eff;
  logic [5:0]         avg_sh;
  logic [44:0]        acc_new;
  logic [8:0]         cnt_new;
  logic               batch_done;
  logic [10*NCH-1:0]  int_nxt;
  logic [7*NCH-1:0]   frac_nxt;

  // Next-state, capture selection and error detection.
  always_comb begin
    state_nxt   = state;
    got_nxt     = got;
    take        = '0;
    lost        = 1'b0;
    start_frame = 1'b0;
    tmo_hit     = 1'b0;
    dval_miss   = 1'b0;
    load_dp     = 1'b0;
    case (state)
      IDLE: begin
        if (|(ch_vld & cfg_mask)) begin
          start_frame = 1'b1;
          take        = ch_vld & cfg_mask;
          got_nxt     = ch_vld & cfg_mask;
          load_dp     = ((ch_vld & cfg_mask) == cfg_mask);
          state_nxt   = ((ch_vld & cfg_mask) == cfg_mask) ? ISSUE : COLLECT;
        end else begin
          state_nxt = IDLE;
        end
      end
      COLLECT: begin
        take    = ch_vld & mask_sh & ~got;
        got_nxt = got | (ch_vld & mask_sh);
        lost    = |(ch_vld & mask_sh & got);
        if ((got | (ch_vld & mask_sh)) == mask_sh) begin
          state_nxt = ISSUE;
          load_dp   = 1'b1;
        end else if ((tmo_sh != '0) && (timer == tmo_sh)) begin
          state_nxt = ISSUE;
          load_dp   = 1'b1;
          tmo_hit   = 1'b1;
        end else begin
          state_nxt = COLLECT;
        end
      end
      ISSUE: begin
        lost      = |(ch_vld & mask_sh);
        state_nxt = WAIT;
      end
      WAIT: begin
        lost = |(ch_vld & mask_sh);
        if (dp_dval) begin
          state_nxt = ACC;
        end else if (wait_cnt == WAIT_LIM) begin
          dval_miss = 1'b1;
          got_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      ACC: begin
        lost      = |(ch_vld & mask_sh);
        got_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        got_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath operands: captured value, this cycle's hit, or zero for absent channels.
  always_comb begin
    int_nxt  = '0;
    frac_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (got_nxt[i]) begin
        if (take[i]) begin
          int_nxt[i*10 +: 10] = ch_int[i*10 +: 10];
          frac_nxt[i*7 +: 7]  = ch_frac[i*7 +: 7];
        end else begin
          int_nxt[i*10 +: 10] = cap_int[i];
          frac_nxt[i*7 +: 7]  = cap_frac[i];
        end
      end else begin
        int_nxt[i*10 +: 10] = 10'd0;
        frac_nxt[i*7 +: 7]  = 7'd0;
      end
    end
  end

  // Averaging arithmetic; navg above 8 saturates so the 45-bit accumulator cannot overflow.
  always_comb begin
    navg_eff   = (navg_sh > 4'd8) ? 4'd8 : navg_sh;
    avg_sh     = {2'b00, navg_eff};
    acc_new    = acc + {8'd0, sum_q};
    cnt_new    = frame_cnt + 9'd1;
    batch_done = (cnt_new == (9'd1 << navg_eff));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame capture, shadows, timers and datapath operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      got      <= '0;
      mask_sh  <= '0;
      tmo_sh   <= '0;
      timer    <= '0;
      partial  <= 1'b0;
      wait_cnt <= 8'd0;
      navg_sh  <= 4'd0;
      sum_q    <= 37'd0;
      dp_int   <= '0;
      dp_frac  <= '0;
      for (int i = 0; i < NCH; i++) begin
        cap_int[i]  <= 10'd0;
        cap_frac[i] <= 7'd0;
      end
    end else begin
      got <= got_nxt;
      for (int i = 0; i < NCH; i++) begin
        if (take[i]) begin
          cap_int[i]  <= ch_int[i*10 +: 10];
          cap_frac[i] <= ch_frac[i*7 +: 7];
        end
      end
      if (start_frame) begin
        mask_sh <= cfg_mask;
        tmo_sh  <= cfg_timeout;
        partial <= 1'b0;
        timer   <= '0;
        if (frame_cnt == 9'd0) navg_sh <= cfg_navg;
      end else if (state == COLLECT) begin
        timer <= timer + TMO_W'(1);
      end
      if (tmo_hit) partial <= 1'b1;
      if (state == ISSUE) begin
        wait_cnt <= 8'd0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if ((state == WAIT) && dp_dval) sum_q <= dp_sum;
      if (load_dp) begin
        dp_int  <= int_nxt;
        dp_frac <= frac_nxt;
      end
    end
  end

  // Accumulation, result presentation and registered status/error strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= 45'd0;
      frame_cnt   <= 9'd0;
      partial_acc <= 1'b0;
      res_data    <= 37'd0;
      res_vld     <= 1'b0;
      res_partial <= 1'b0;
      dp_start    <= 1'b0;
      busy        <= 1'b0;
      err_lost    <= 1'b0;
      err_dval    <= 1'b0;
    end else begin
      dp_start <= (state_nxt == ISSUE);
      busy     <= (state_nxt != IDLE);
      err_lost <= lost;
      err_dval <= dval_miss;
      res_vld  <= 1'b0;
      if (state == ACC) begin
        if (batch_done) begin
          res_data    <= acc_new[avg_sh +: 37];
          res_vld     <= 1'b1;
          res_partial <= partial_acc | partial;
          acc         <= 45'd0;
          frame_cnt   <= 9'd0;
          partial_acc <= 1'b0;
        end else begin
          acc         <= acc_new;
          frame_cnt   <= cnt_new;
          partial_acc <= partial_acc | partial;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_sum_sched.sv
// Directed bench for tdc_sum_sched with a behavioural datapath model and a result scoreboard.
module tb_tdc_sum_sched;
  localparam int NCH   = 16;
  localparam int LAT   = 6;
  localparam int TMO_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NCH-1:0]    ch_vld = '0;
  logic [10*NCH-1:0] ch_int = '0;
  logic [7*NCH-1:0]  ch_frac = '0;
  logic [NCH-1:0]    cfg_mask = '0;
  logic [TMO_W-1:0]  cfg_timeout = '0;
  logic [3:0]        cfg_navg = '0;
  logic              dp_start;
  logic [10*NCH-1:0] dp_int;
  logic [7*NCH-1:0]  dp_frac;
  logic [36:0]       dp_sum;
  logic              dp_dval;
  logic [36:0]       res_data;
  logic              res_vld, res_partial, busy, err_lost, err_dval;

  tdc_sum_sched #(.NCH(NCH), .LAT(LAT), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .ch_vld(ch_vld), .ch_int(ch_int), .ch_frac(ch_frac),
    .cfg_mask(cfg_mask), .cfg_timeout(cfg_timeout), .cfg_navg(cfg_navg),
    .dp_start(dp_start), .dp_int(dp_int), .dp_frac(dp_frac), .dp_sum(dp_sum),
    .dp_dval(dp_dval), .res_data(res_data), .res_vld(res_vld), .res_partial(res_partial),
    .busy(busy), .err_lost(err_lost), .err_dval(err_dval)
  );

  always #5 clk = ~clk;

  // Datapath model: sum of int*50+frac, dval LAT cycles after the start cycle.
  logic [LAT-1:0] pipe = '0;
  logic [36:0]    msum = '0;
  logic           dval_en = 1'b1;

  function automatic logic [36:0] model_sum(input logic [10*NCH-1:0] di, input logic [7*NCH-1:0] df);
    logic [36:0] s;
    s = 37'd0;
    for (int i = 0; i < NCH; i++) s = s + 37'(di[i*10 +: 10]) * 37'd50 + 37'(df[i*7 +: 7]);
    return s;
  endfunction

  always @(posedge clk) begin
    pipe <= {pipe[LAT-2:0], dp_start & dval_en};
    if (dp_start) msum <= model_sum(dp_int, dp_frac);
  end
  assign dp_dval = pipe[LAT-1];
  assign dp_sum  = msum;

  int tests = 0, fails = 0;
  int n_start = 0, n_lost = 0, n_dval = 0, n_res = 0;
  logic [36:0] exp_q[$];
  logic        exp_p[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Scoreboard: every result strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (dp_start) n_start++;
    if (err_lost) n_lost++;
    if (err_dval) n_dval++;
    if (res_vld) begin
      n_res++;
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL res_unexpected: observed res_vld with %0d pending, expected at least 1", exp_q.size());
      end
      if (exp_q.size() > 0) begin
        check("res_data", 64'(res_data), 64'(exp_q.pop_front()));
        check("res_partial", 64'(res_partial), 64'(exp_p.pop_front()));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_hit(input int ch, input int iv, input int fv);
    ch_vld[ch]          = 1'b1;
    ch_int[ch*10 +: 10] = 10'(iv);
    ch_frac[ch*7 +: 7]  = 7'(fv);
    tick();
    ch_vld = '0;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return res_vld;
      1:       return dp_start;
      2:       return err_dval;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w, output int n);
    n = 0;
    while (!sel(w) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $error("FAIL %s: waited %0d cycles, required event within 200", tag, n);
    end
  endtask

  task automatic push(input logic [36:0] d, input logic p);
    exp_q.push_back(d);
    exp_p.push_back(p);
  endtask

  initial begin
    int n, s0, l0, r0;
    repeat (3) tick();
    check("rst_dp_start", 64'(dp_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res", 64'({res_vld, res_partial, res_data}), 64'd0);
    check("rst_err", 64'({err_lost, err_dval}), 64'd0);
    check("rst_dp_int", 64'(dp_int[63:0]), 64'd0);
    rst = 1'b1;
    tick();

    // Ignored hits with an empty mask.
    do_hit(0, 1, 1);
    tick();
    check("mask0_busy", 64'(busy), 64'd0);
    check("mask0_lost", 64'(n_lost), 64'd0);

    // Single channel frame, latency check.
    cfg_mask = 16'h0001; cfg_navg = 4'd0; cfg_timeout = '0;
    push(37'd503, 1'b0);
    do_hit(0, 10, 3);
    check("t1_start", 64'(dp_start), 64'd1);
    check("t1_dp_int0", 64'(dp_int[9:0]), 64'd10);
    wait_for("t1_res", 0, n);
    check("t1_res_lat", 64'(n), 64'd8);
    tick();
    check("t1_idle", 64'(busy), 64'd0);

    // All 16 channels over 20 cycles.
    cfg_mask = 16'hFFFF;
    push(37'd816, 1'b0);
    s0 = n_start;
    for (int i = 0; i < NCH; i++) begin
      if (i == NCH - 1) check("t2_no_early_start", 64'(n_start - s0), 64'd0);
      do_hit(i, 1, 1);
      if ((i % 4) == 3 && i != NCH - 1) tick();
    end
    check("t2_start", 64'(dp_start), 64'd1);
    wait_for("t2_res", 0, n);
    check("t2_one_start", 64'(n_start - s0), 64'd1);
    tick();

    // Timeout with a missing channel.
    cfg_mask = 16'h0003; cfg_timeout = 12'd50;
    push(37'd100, 1'b1);
    do_hit(0, 2, 0);
    wait_for("t3_start", 1, n);
    check("t3_tmo_cycles", 64'(n), 64'd51);
    check("t3_dp_int1", 64'(dp_int[19:10]), 64'd0);
    check("t3_dp_int0", 64'(dp_int[9:0]), 64'd2);
    wait_for("t3_res", 0, n);
    tick();

    // Average of four frames.
    cfg_mask = 16'h0001; cfg_timeout = '0; cfg_navg = 4'd2;
    r0 = n_res;
    for (int f = 0; f < 4; f++) begin
      if (f == 3) push(37'd101, 1'b0);
      do_hit(0, 2, f);
      wait_for("t4_idle", 3, n);
      tick();
    end
    check("t4_one_res", 64'(n_res - r0), 64'd1);

    // Lost hits: duplicate in COLLECT, masked-off channel silent, hit during WAIT.
    cfg_mask = 16'h0003; cfg_navg = 4'd0;
    push(37'd257, 1'b0);
    l0 = n_lost;
    do_hit(0, 5, 0);
    do_hit(0, 9, 0);
    check("t5_lost_collect", 64'(err_lost), 64'd1);
    do_hit(5, 3, 3);
    check("t5_masked_silent", 64'(err_lost), 64'd0);
    do_hit(1, 0, 7);
    check("t5_start", 64'(dp_start), 64'd1);
    check("t5_first_capture", 64'(dp_int[9:0]), 64'd5);
    tick();
    do_hit(0, 1, 1);
    check("t5_lost_wait", 64'(err_lost), 64'd1);
    wait_for("t5_res", 0, n);
    check("t5_lost_count", 64'(n_lost - l0), 64'd2);
    tick();

    // Datapath never answers.
    cfg_mask = 16'h0001; dval_en = 1'b0;
    r0 = n_res;
    do_hit(0, 3, 3);
    wait_for("t6_err_dval", 2, n);
    check("t6_dval_cycles", 64'(n), 64'd8);
    check("t6_idle", 64'(busy), 64'd0);
    dval_en = 1'b1;
    tick();

    // Reset during WAIT; the late dval must be ignored.
    do_hit(0, 4, 4);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_dp", 64'({dp_start, dp_int[63:0]}), 64'd0);
    check("t7_err", 64'({err_lost, err_dval, res_vld, res_partial}), 64'd0);
    check("t7_res_data", 64'(res_data), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    repeat (10) tick();
    check("t7_still_idle", 64'(busy), 64'd0);
    check("t7_no_res", 64'(n_res - r0), 64'd0);

    // Recovery frame.
    push(37'd51, 1'b0);
    do_hit(0, 1, 1);
    wait_for("t8_res", 0, n);
    tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
